tdm_demux: RTL and testbench

Serial time-division demultiplexer, the receive-side counterpart of the team's channel mux/serializer.
- Samples a serial bitstream framed by a frame_sync marker.
- Reassembles N_CH fixed-width channel slots, MSB first.
- Presents each completed slot on its own registered output with a one-cycle valid strobe.
- Sits between the serial link front-end and per-channel consumer logic.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_slot_shifter.sv | 58 +++++
 rtl/tdm_demux.sv | 140 ++++++++++++++
 tb/tb_tdm_demux.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_pkg : shared types, defaults and slot-offset helper for tdm_demux |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tdm_pkg;

  localparam int TDM_N_CH = 4;
  localparam int TDM_W    = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  function automatic int unsigned slot_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_slot_shifter : MSB-first slot shift register with bit counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdm_slot_shifter
  import tdm_pkg::*;
#(
  parameter int W = TDM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] slot_word,
  output logic         slot_last,
  output logic         slot_idle
);

  localparam int BCW = (W > 1) ? $clog2(W) : 1;

  // Only W-1 bits are stored; the final bit of a slot is taken straight from din.
  logic [W-2:0]   shift_q, shift_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;

  assign slot_word = {shift_q, din};
  assign slot_last = (bit_cnt_q == BCW'(W - 1));
  assign slot_idle = (bit_cnt_q == '0);

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (start) begin
      shift_d   = (W-1)'(din);
      bit_cnt_d = BCW'(1);
    end else if (shift_en) begin
      shift_d   = (W-1)'({shift_q, din});
      bit_cnt_d = slot_last ? '0 : bit_cnt_q + BCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux : serial TDM frame demultiplexer with per-slot strobes     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int W    = TDM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_en,
  input  logic              din,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int CCW = (N_CH > 1) ? $clog2(N_CH) : 1;

  tdm_state_e          state_q, state_d;
  logic [CCW-1:0]      ch_cnt_q, ch_cnt_d;
  logic [N_CH*W-1:0]   ch_data_q, ch_data_d;
  logic [N_CH-1:0]     ch_valid_q, ch_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q, sync_err_d;
  logic                locked_q, locked_d;

  logic                sh_clear, sh_start, sh_shift, slot_wr;
  logic [W-1:0]        slot_word;
  logic                slot_last, slot_idle;

  tdm_slot_shifter #(
    .W (W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (sh_clear),
    .start     (sh_start),
    .shift_en  (sh_shift),
    .din       (din),
    .slot_word (slot_word),
    .slot_last (slot_last),
    .slot_idle (slot_idle)
  );

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    sh_clear     = 1'b0;
    sh_start     = 1'b0;
    sh_shift     = 1'b0;
    slot_wr      = 1'b0;

    if (din_en) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            sh_start = 1'b1;
            ch_cnt_d = '0;
            state_d  = RECV;
          end
        end
        RECV: begin
          // Idle bit counter with ch_cnt=0 in RECV only occurs right after a frame's last slot.
          if (slot_idle && (ch_cnt_q == '0)) begin
            if (frame_sync) begin
              sh_start = 1'b1;
            end else begin
              sh_clear = 1'b1;
              state_d  = HUNT;
            end
          end else if (frame_sync) begin
            sync_err_d = 1'b1;
            sh_start   = 1'b1;
            ch_cnt_d   = '0;
          end else begin
            sh_shift = 1'b1;
            if (slot_last) begin
              slot_wr = 1'b1;
              if (ch_cnt_q == CCW'(N_CH - 1)) begin
                ch_cnt_d     = '0;
                frame_done_d = 1'b1;
              end else begin
                ch_cnt_d = ch_cnt_q + CCW'(1);
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    for (int k = 0; k < N_CH; k++) begin
      if (slot_wr && (ch_cnt_q == CCW'(k))) begin
        ch_data_d[slot_lo(k, W) +: W] = slot_word;
        ch_valid_d[k]                 = 1'b1;
      end
    end

    locked_d = (state_d == RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      ch_cnt_q     <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= locked_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdm_demux : directed scoreboard bench for tdm_demux (4 x 8 bit)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_en = 1'b0;
  logic        din = 1'b0;
  logic        frame_sync = 1'b0;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic        sync_err;
  logic        locked;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_en     (din_en),
    .din        (din),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  v;
    logic [31:0] d;
    logic        fd;
    logic        se;
  } exp_t;

  typedef struct {
    int          cyc;
    string       name;
    logic        lk;
    logic [31:0] d;
  } st_t;

  exp_t ev_q[$];
  st_t  st_q[$];
  int   n_asserts = 0;
  int   n_fail = 0;
  logic done = 1'b0;
  exp_t e_cur;
  st_t  s_cur;

  // Strobe event expected nbits accepted bits from now, each preceded by gap idle cycles.
  task automatic expect_ev(input int nbits, input int gap, input logic [3:0] v,
                           input logic [31:0] d, input logic fd, input logic se);
    exp_t e;
    e.cyc = cyc + nbits * (gap + 1);
    e.v = v; e.d = d; e.fd = fd; e.se = se;
    ev_q.push_back(e);
  endtask

  task automatic expect_state(input string name, input logic lk, input logic [31:0] d);
    st_t s;
    s.cyc = cyc; s.name = name; s.lk = lk; s.d = d;
    st_q.push_back(s);
  endtask

  task automatic send_bit(input logic b, input logic fs, input int gap);
    din_en = 1'b0;
    frame_sync = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    din_en = 1'b1;
    din = b;
    frame_sync = fs;
    @(posedge clk); #1;
    din_en = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic sync, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], sync && (i == 7), gap);
  endtask

  task automatic send_frame(input logic [31:0] w, input int gap, input logic [31:0] base);
    logic [31:0] acc;
    acc = base;
    for (int c = 0; c < 4; c++) begin
      acc[c*8 +: 8] = w[c*8 +: 8];
      expect_ev(8, gap, 4'(1 << c), acc, c == 3, 1'b0);
      send_byte(w[c*8 +: 8], c == 0, gap);
    end
  endtask

  // Monitor: owns all counters; checks strobes and state snapshots against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        e_cur = ev_q.pop_front();
        n_asserts++; n_fail++;
        $display("FAIL missing_strobe: got no strobe, wanted at cyc %0d v=%b d=%h", e_cur.cyc, e_cur.v, e_cur.d);
      end
      if (ch_valid != 4'b0 || frame_done || sync_err) begin
        n_asserts++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe @cyc %0d: got v=%b fd=%b se=%b d=%h, wanted no strobe",
                   cyc, ch_valid, frame_done, sync_err, ch_data);
        end else begin
          e_cur = ev_q.pop_front();
          if (e_cur.cyc != cyc || ch_valid !== e_cur.v || ch_data !== e_cur.d ||
              frame_done !== e_cur.fd || sync_err !== e_cur.se) begin
            n_fail++;
            $display("FAIL strobe @cyc %0d: got v=%b d=%h fd=%b se=%b, wanted cyc %0d v=%b d=%h fd=%b se=%b",
                     cyc, ch_valid, ch_data, frame_done, sync_err,
                     e_cur.cyc, e_cur.v, e_cur.d, e_cur.fd, e_cur.se);
          end
        end
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        s_cur = st_q.pop_front();
        n_asserts++;
        if (locked !== s_cur.lk || ch_data !== s_cur.d) begin
          n_fail++;
          $display("FAIL %s: got locked=%b d=%h, wanted locked=%b d=%h",
                   s_cur.name, locked, ch_data, s_cur.lk, s_cur.d);
        end
      end
      if (done) begin
        n_asserts++;
        if (ev_q.size() != 0 || st_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: got %0d strobes and %0d snapshots pending, wanted 0", ev_q.size(), st_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_state("reset_state", 1'b0, 32'h0);

    // Idle hunting: no sync, nothing may be produced.
    for (int i = 0; i < 40; i++) send_bit(1'(i), 1'b0, 0);
    expect_state("idle_hunt", 1'b0, 32'h0);

    // Single frame, then one unsynced bit drops lock.
    send_frame(32'h01FF3CA5, 0, 32'h0);
    expect_state("single_locked", 1'b1, 32'h01FF3CA5);
    send_bit(1'b1, 1'b0, 0);
    expect_state("single_unlock", 1'b0, 32'h01FF3CA5);

    // Back-to-back frames with no gap.
    send_frame(32'h44332211, 0, 32'h01FF3CA5);
    expect_state("b2b_between", 1'b1, 32'h44332211);
    send_frame(32'h88776655, 0, 32'h44332211);
    expect_state("b2b_final", 1'b1, 32'h88776655);
    send_bit(1'b0, 1'b0, 0);
    expect_state("b2b_unlock", 1'b0, 32'h88776655);

    // din_en every third cycle.
    send_frame(32'h01FF3CA5, 2, 32'h88776655);
    expect_state("gated_final", 1'b1, 32'h01FF3CA5);
    send_bit(1'b0, 1'b0, 2);
    expect_state("gated_unlock", 1'b0, 32'h01FF3CA5);

    // Early sync at bit 5 of ch1.
    expect_ev(8, 0, 4'b0001, 32'h01FF3C12, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    expect_ev(1, 0, 4'b0000, 32'h01FF3C12, 1'b0, 1'b1);
    send_frame(32'hDDCCBBAA, 0, 32'h01FF3C12);
    expect_state("resync_locked", 1'b1, 32'hDDCCBBAA);

    // Reset after 12 bits of a frame.
    expect_ev(8, 0, 4'b0001, 32'hDDCCBBEE, 1'b0, 1'b0);
    send_byte(8'hEE, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_state("reset_mid", 1'b0, 32'h0);
    send_frame(32'h01FF3CA5, 0, 32'h0);
    expect_state("post_reset", 1'b1, 32'h01FF3CA5);
    send_bit(1'b0, 1'b0, 0);
    expect_state("post_unlock", 1'b0, 32'h01FF3CA5);

    repeat (3) begin @(posedge clk); #1; end
    done = 1'b1;
  end

endmodule
`default_nettype wire
